// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_CH requesters onto one external memory bus, one
// transaction at a time, with fixed-priority or round-robin selection and a response timeout.
//   state | meaning
//   IDLE  | no transaction; arbitrate when any req_i is high
//   ISSUE | strobe driven, waiting for bus_busy_i low to hand it over
//   WAIT  | strobe accepted, waiting for bus_ack_i or the timeout
//   RESP  | one-cycle done/err pulse to the owner, then release the bus
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  output logic [NUM_CH-1:0]        grant_o,
  output logic [NUM_CH-1:0]        done_o,
  output logic                     err_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        bus_addr_o,
  output logic [DATA_W-1:0]        bus_wdata_o,
  output logic                     bus_read_o,
  output logic                     bus_write_o,
  input  logic                     bus_busy_i,
  input  logic                     bus_ack_i,
  input  logic [DATA_W-1:0]        bus_rdata_i
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   ch_q;
  logic [NUM_CH-1:0] grant_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NUM_CH-1:0] lo_oh, hi_oh, win_oh;
  logic [CH_W-1:0]   lo_idx, hi_idx, win_idx;
  logic              hi_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              timeout_hit;

  // Descending scan leaves the lowest requester overall (lo) and the lowest one above rr_ptr (hi).
  always_comb begin
    lo_oh   = '0;
    hi_oh   = '0;
    lo_idx  = '0;
    hi_idx  = '0;
    hi_any  = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_oh    = '0;
        lo_oh[i] = 1'b1;
        lo_idx   = CH_W'(i);
      end
      if (req_i[i] && (i > int'(rr_ptr))) begin
        hi_any   = 1'b1;
        hi_oh    = '0;
        hi_oh[i] = 1'b1;
        hi_idx   = CH_W'(i);
      end
    end
    if ((RR_MODE != 0) && hi_any) begin
      win_oh  = hi_oh;
      win_idx = hi_idx;
    end else begin
      win_oh  = lo_oh;
      win_idx = lo_idx;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idx == CH_W'(i)) begin
        sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
        sel_we    = we_i[i];
      end
    end
  end

  // Down-counter loaded with TIMEOUT on WAIT entry; terminal count without ack is a timeout.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == '0) && !bus_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= CH_W'(NUM_CH - 1);
      ch_q    <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            ch_q    <= win_idx;
            grant_q <= win_oh;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            err_q   <= 1'b0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus_busy_i) begin
            cnt_q <= CNT_W'(TIMEOUT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_ack_i) begin
            rdata_q <= bus_rdata_i;
            state   <= S_RESP;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr  <= ch_q;
          grant_q <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes and done decode straight from state so an async reset drops them at once.
  assign grant_o     = grant_q;
  assign done_o      = (state == S_RESP) ? grant_q : '0;
  assign err_o       = (state == S_RESP) && err_q;
  assign rdata_o     = rdata_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_read_o  = (state == S_ISSUE) && !we_q;
  assign bus_write_o = (state == S_ISSUE) && we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share stimulus and are
// checked every cycle against a transaction-level model, plus directed literal expectations.
module tb_mem_arbiter;

  localparam int NCH = 2;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NCH-1:0]    req_i = '0;
  logic [NCH-1:0]    we_i = '0;
  logic [NCH*32-1:0] addr_i = '0;
  logic [NCH*32-1:0] wdata_i = '0;
  logic              bus_busy_i = 1'b0;
  logic              bus_ack_i;
  logic [31:0]       bus_rdata_i;

  logic [NCH-1:0] grant_a, done_a, grant_b, done_b;
  logic           err_a, err_b, rd_a, wr_a, rd_b, wr_b;
  logic [31:0]    rdata_a, baddr_a, bwdata_a, rdata_b, baddr_b, bwdata_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .grant_o(grant_a), .done_o(done_a), .err_o(err_a), .rdata_o(rdata_a),
    .bus_addr_o(baddr_a), .bus_wdata_o(bwdata_a), .bus_read_o(rd_a), .bus_write_o(wr_a),
    .bus_busy_i(bus_busy_i), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i));

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .grant_o(grant_b), .done_o(done_b), .err_o(err_b), .rdata_o(rdata_b),
    .bus_addr_o(baddr_b), .bus_wdata_o(bwdata_b), .bus_read_o(rd_b), .bus_write_o(wr_b),
    .bus_busy_i(bus_busy_i), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- behavioural model (index 0 = round-robin, 1 = fixed priority)
  int          own[2]    = '{-1, -1};
  bit          acc[2]    = '{0, 0};
  bit          fin[2]    = '{0, 0};
  int          waited[2] = '{0, 0};
  int          last[2]   = '{NCH - 1, NCH - 1};
  bit          m_err[2]  = '{0, 0};
  bit          m_we[2]   = '{0, 0};
  logic [31:0] m_rdata[2] = '{0, 0};
  logic [31:0] m_addr[2]  = '{0, 0};
  logic [31:0] m_wdata[2] = '{0, 0};

  function automatic int pick(input bit rr, input logic [NCH-1:0] req, input int lst);
    if (!rr) begin
      for (int c = 0; c < NCH; c++) if (req[c]) return c;
    end else begin
      for (int k = 1; k <= NCH; k++) if (req[(lst + k) % NCH]) return (lst + k) % NCH;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        own[d] = -1; acc[d] = 0; fin[d] = 0; waited[d] = 0; last[d] = NCH - 1;
        m_err[d] = 0; m_we[d] = 0; m_rdata[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
      end else if (fin[d]) begin
        last[d] = own[d];
        own[d]  = -1;
        fin[d]  = 0;
      end else if (own[d] < 0) begin
        if (req_i != '0) begin
          own[d]     = pick(d == 0, req_i, last[d]);
          m_addr[d]  = addr_i[own[d]*32 +: 32];
          m_wdata[d] = wdata_i[own[d]*32 +: 32];
          m_we[d]    = we_i[own[d]];
          acc[d]     = 0;
          m_err[d]   = 0;
        end
      end else if (!acc[d]) begin
        if (!bus_busy_i) begin
          acc[d]    = 1;
          waited[d] = 0;
        end
      end else if (bus_ack_i) begin
        m_rdata[d] = bus_rdata_i;
        fin[d]     = 1;
      end else if (waited[d] == TO) begin
        m_rdata[d] = '0;
        m_err[d]   = 1;
        fin[d]     = 1;
      end else begin
        waited[d]++;
      end
    end
  end

  task automatic cmp(input int d, input logic [NCH-1:0] g, input logic [NCH-1:0] dn,
                     input logic e, input logic [31:0] rd, input logic [31:0] ba,
                     input logic [31:0] bw, input logic r, input logic w);
    string p;
    logic [NCH-1:0] eg;
    bit strb;
    p    = (d == 0) ? "rr" : "fp";
    eg   = (own[d] >= 0) ? NCH'(1 << own[d]) : '0;
    strb = (own[d] >= 0) && !acc[d];
    check({p, "_grant"}, 32'(g), 32'(eg));
    check({p, "_done"}, 32'(dn), fin[d] ? 32'(eg) : 32'd0);
    check({p, "_err"}, 32'(e), 32'(fin[d] && m_err[d]));
    check({p, "_rdata"}, rd, m_rdata[d]);
    check({p, "_read"}, 32'(r), 32'(strb && !m_we[d]));
    check({p, "_write"}, 32'(w), 32'(strb && m_we[d]));
    if (strb) begin
      check({p, "_bus_addr"}, ba, m_addr[d]);
      check({p, "_bus_wdata"}, bw, m_wdata[d]);
    end
  endtask

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, grant_a, done_a, err_a, rdata_a, baddr_a, bwdata_a, rd_a, wr_a);
      cmp(1, grant_b, done_b, err_b, rdata_b, baddr_b, bwdata_b, rd_b, wr_b);
    end
  end

  logic [NCH-1:0] log_a[$];
  logic [NCH-1:0] log_b[$];
  initial forever begin
    @(negedge clk);
    if (done_a != '0) log_a.push_back(grant_a);
    if (done_b != '0) log_b.push_back(grant_b);
  end

  // ---------------- bus responder: acks ack_lat cycles after the accept edge
  bit          acc_seen = 0;
  bit          ack_en = 1;
  int          ack_lat = 0;
  logic [31:0] rd_val = 32'h0;
  int          stray_req = 0;
  int          stray_done = 0;
  int          wcnt = -1;

  initial forever begin
    @(negedge clk);
    acc_seen = (rd_a || wr_a) && !bus_busy_i;
  end

  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack_i   = 1'b0;
      bus_rdata_i = ~rd_val;
      if (rst) wcnt = -1;
      else if (acc_seen) wcnt = 0;
      else if (wcnt >= 0) wcnt++;
      if (wcnt > 20) wcnt = -1;
      if (wcnt >= 0 && ack_en && wcnt == ack_lat) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd_val;
        wcnt        = -1;
      end else if (wcnt < 0 && stray_req != stray_done) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd_val;
        stray_done++;
      end
    end
  end

  // ---------------- directed stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
    we_i[c]             = we;
    addr_i[c*32 +: 32]  = a;
    wdata_i[c*32 +: 32] = wd;
  endtask

  task automatic wait_done(input string name, output int k);
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (done_a != '0) return;
    end
    bound_fail(name);
  endtask

  int k;
  int nd;

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1;
    tick(); tick();
    check("reset_grant", 32'(grant_a), 32'd0);
    check("reset_rdata", rdata_a, 32'd0);
    rst = 1'b0;
    tick();

    // single read ch0, ack two cycles after the accept edge
    ack_lat = 2; rd_val = 32'hDEADBEEF;
    set_ch(0, 1'b0, 32'h100, 32'h0);
    req_i = 2'b01;
    tick();
    check("t1_read_strobe", 32'(rd_a), 32'd1);
    check("t1_grant", 32'(grant_a), 32'h1);
    tick();
    tick(); tick(); tick();
    check("t1_req_to_done", 32'(done_a), 32'h1);
    check("t1_rdata", rdata_a, 32'hDEADBEEF);
    check("t1_err", 32'(err_a), 32'd0);
    req_i = 2'b00;
    tick();
    check("t1_done_once", 32'(done_a), 32'd0);

    // back-pressured write on ch1; request inputs scrambled while the strobe is held
    ack_lat = 1; rd_val = 32'h0000_0031;
    set_ch(1, 1'b1, 32'h20, 32'h55);
    req_i = 2'b10; bus_busy_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_write_held", 32'(wr_a), 32'd1);
      check("t3_read_low", 32'(rd_a), 32'd0);
      check("t3_addr_held", baddr_a, 32'h20);
      check("t3_data_held", bwdata_a, 32'h55);
      if (i == 1) set_ch(1, 1'b0, 32'hFFFF, 32'hAAAA);
      tick();
    end
    bus_busy_i = 1'b0;
    check("t3_cycle6_write", 32'(wr_a), 32'd1);
    tick();
    check("t3_accepted", 32'(wr_a), 32'd0);
    wait_done("t3_done", k);
    check("t3_done_ch1", 32'(done_a), 32'h2);
    req_i = 2'b00;
    tick();

    // timeout: no ack, done with err 9 cycles after WAIT entry
    ack_en = 0;
    set_ch(0, 1'b0, 32'h400, 32'h0);
    req_i = 2'b01;
    tick(); tick();
    req_i = 2'b00;
    wait_done("t4_done", k);
    check("t4_timeout_cycles", 32'(k), 32'd9);
    check("t4_err", 32'(err_a), 32'd1);
    check("t4_rdata_zero", rdata_a, 32'd0);
    tick();

    // ack exactly at the limit counts as success
    ack_en = 1; ack_lat = TO; rd_val = 32'h1234_5678;
    set_ch(1, 1'b0, 32'h440, 32'h0);
    req_i = 2'b10;
    tick(); tick();
    req_i = 2'b00;
    wait_done("t4b_done", k);
    check("t4b_cycles", 32'(k), 32'd9);
    check("t4b_err", 32'(err_a), 32'd0);
    check("t4b_rdata", rdata_a, 32'h1234_5678);
    tick();

    // request dropped in WAIT, then a stray ack while idle
    ack_lat = 3; rd_val = 32'h0000_0066;
    set_ch(0, 1'b0, 32'h600, 32'h0);
    req_i = 2'b01;
    tick(); tick(); tick();
    req_i = 2'b00;
    wait_done("t6_done", k);
    check("t6_done_ch0", 32'(done_a), 32'h1);
    tick(); tick();
    rd_val = 32'h0000_7777;
    stray_req++;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_a != '0) nd++;
    end
    check("t6_stray_dones", 32'(nd), 32'd0);
    check("t6_rdata_held", rdata_a, 32'h0000_0066);

    // reset in the middle of WAIT
    ack_en = 0;
    set_ch(1, 1'b0, 32'h500, 32'h0);
    req_i = 2'b10;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t5_grant_async", 32'(grant_a), 32'd0);
    check("t5_strobe_async", 32'(rd_a || wr_a), 32'd0);
    check("t5_done_async", 32'(done_a), 32'd0);
    check("t5_rdata_async", rdata_a, 32'd0);
    req_i = 2'b00;
    tick(); tick();
    rst = 1'b0;
    ack_en = 1; ack_lat = 0; rd_val = 32'h0000_0A0A;
    tick();

    // contention with both requests held
    log_a.delete();
    log_b.delete();
    set_ch(0, 1'b0, 32'h200, 32'hA0);
    set_ch(1, 1'b1, 32'h300, 32'hB1);
    req_i = 2'b11;
    nd = 0;
    k = 0;
    while (nd < 4 && k < 60) begin
      tick();
      k++;
      if (done_a != '0) nd++;
    end
    if (nd < 4) bound_fail("t2_done_count");
    req_i = 2'b00;
    tick(); tick();
    check("t2_log_size", 32'(log_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_a.size(); i++)
      check($sformatf("t2_rr_grant%0d", i), 32'(log_a[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
    for (int i = 0; i < 4 && i < log_b.size(); i++)
      check($sformatf("t2_fp_grant%0d", i), 32'(log_b[i]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
